// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit serializer: FSM state encoding,
// counter sizing and the bit-selection rule for the shift register.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int GAP_CNT_W = 8;

  // Width of the bit counter; never below one bit.
  function automatic int cnt_width(input int data_w);
    return (data_w < 2) ? 1 : $clog2(data_w);
  endfunction

  // Bit presented next: the top bit of a data_w-wide register, or bit 0.
  function automatic logic next_bit(input logic [31:0] shift_reg,
                                    input int          data_w,
                                    input logic        msb_first);
    logic [4:0] msb_idx;
    msb_idx = 5'(data_w - 1);
    return msb_first ? shift_reg[msb_idx] : shift_reg[0];
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: valid/ready word input, one bit per clock out,
// optional idle gap after each word and a synchronous abort flush.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              abort,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              word_start,
  output logic              busy
);

  localparam int                   CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                 state_q;
  logic [DATA_W-1:0]      shift_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [GAP_CNT_W-1:0]   gap_cnt_q;
  logic                   ser_out_q;
  logic                   ser_valid_q;
  logic                   word_start_q;
  logic                   busy_q;

  logic last_bit;
  logic handshake;

  // Shift register holds only the bits not yet presented on ser_out.
  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] sr);
    return MSB_FIRST ? (sr << 1) : (sr >> 1);
  endfunction

  assign last_bit  = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
  assign s_ready   = !abort && ((state_q == IDLE) || ((GAP_CYCLES == 0) && last_bit));
  assign handshake = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      word_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else if (handshake) begin
      // Covers both the idle load and the bubble-free reload on the last bit.
      state_q      <= SHIFT;
      ser_out_q    <= next_bit(32'(s_data), DATA_W, MSB_FIRST);
      shift_q      <= advance(s_data);
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      ser_valid_q  <= 1'b1;
      word_start_q <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      word_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        SHIFT: begin
          if (bit_cnt_q == LAST_BIT) begin
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            if (GAP_CYCLES > 0) begin
              state_q <= GAP;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            ser_out_q <= next_bit(32'(shift_q), DATA_W, MSB_FIRST);
            shift_q   <= advance(shift_q);
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_q == LAST_GAP) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          shift_q     <= '0;
          bit_cnt_q   <= '0;
          gap_cnt_q   <= '0;
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign word_start = word_start_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Randomised self-checking bench for bit_serializer: an MSB-first no-gap
// instance and an LSB-first instance with a 3-cycle gap.
module tb_bit_serializer;

  logic       clk;
  logic       rst;

  logic       a_valid, a_ready, a_abort, a_out, a_sv, a_ws, a_busy;
  logic [7:0] a_data;
  logic       b_valid, b_ready, b_abort, b_out, b_sv, b_ws, b_busy;
  logic [7:0] b_data;

  int n_checks = 0;
  int n_fail   = 0;

  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
    .abort(a_abort), .ser_out(a_out), .ser_valid(a_sv), .word_start(a_ws), .busy(a_busy)
  );

  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
    .abort(b_abort), .ser_out(b_out), .ser_valid(b_sv), .word_start(b_ws), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bit i of the serial stream for word w.
  function automatic logic ref_bit(input logic [7:0] w, input int i, input bit msb);
    return msb ? w[7-i] : w[i];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({a_out, a_sv, a_ws, a_busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_a outputs got %b want 0000", {a_out, a_sv, a_ws, a_busy});
    end
    n_checks++;
    if ({b_out, b_sv, b_ws, b_busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_b outputs got %b want 0000", {b_out, b_sv, b_ws, b_busy});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_ready, b_ready} !== 2'b11) begin
      n_fail++; $display("FAIL reset_ready got %b want 11", {a_ready, b_ready});
    end
    $display("test_reset done");
  endtask

  task automatic test_msb_basic();
    logic [7:0] w;
    for (int n = 0; n < 5; n++) begin
      w = (n == 0) ? 8'hA5 : 8'($urandom);
      @(negedge clk);
      a_valid = 1'b1; a_data = w;
      #1;
      n_checks++;
      if (a_ready !== 1'b1) begin
        n_fail++; $display("FAIL msb_ready got %b want 1", a_ready);
      end
      @(negedge clk);
      a_valid = 1'b0; a_data = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        if (i > 0) begin
          @(negedge clk);
          a_data = 8'($urandom);
        end
        n_checks++;
        if ({a_out, a_sv, a_ws, a_busy} !== {ref_bit(w, i, 1'b1), 1'b1, (i == 0), 1'b1}) begin
          n_fail++;
          $display("FAIL msb_bit word=%h bit=%0d got out/sv/ws/busy=%b want %b", w, i,
                   {a_out, a_sv, a_ws, a_busy}, {ref_bit(w, i, 1'b1), 1'b1, (i == 0), 1'b1});
        end
      end
      @(negedge clk);
      n_checks++;
      if ({a_out, a_sv, a_ws, a_busy} !== 4'b0000) begin
        n_fail++; $display("FAIL msb_after word=%h got %b want 0000", w, {a_out, a_sv, a_ws, a_busy});
      end
      $display("test_msb_basic word %h sent", w);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  w1, w2, w;
    logic [15:0] obs_bits, ref_bits, obs_det, ref_det;
    int          bi;
    for (int n = 0; n < 3; n++) begin
      w1 = (n == 0) ? 8'h99 : 8'($urandom);
      w2 = (n == 0) ? 8'h99 : 8'($urandom);
      @(negedge clk);
      a_valid = 1'b1; a_data = w1;
      for (int c = 1; c <= 16; c++) begin
        @(negedge clk);
        if (c == 1) a_data = w2;
        if (c == 9) a_valid = 1'b0;
        bi = (c - 1) % 8;
        w  = (c <= 8) ? w1 : w2;
        obs_bits[c-1] = a_out;
        ref_bits[c-1] = ref_bit(w, bi, 1'b1);
        n_checks++;
        if ({a_out, a_sv, a_ws, a_busy, a_ready} !==
            {ref_bit(w, bi, 1'b1), 1'b1, (bi == 0), 1'b1, (c == 8 || c == 16)}) begin
          n_fail++;
          $display("FAIL b2b cycle=%0d got out/sv/ws/busy/ready=%b want %b", c,
                   {a_out, a_sv, a_ws, a_busy, a_ready},
                   {ref_bit(w, bi, 1'b1), 1'b1, (bi == 0), 1'b1, (c == 8 || c == 16)});
        end
      end
      @(negedge clk);
      n_checks++;
      if ({a_sv, a_busy} !== 2'b00) begin
        n_fail++; $display("FAIL b2b_end got sv/busy=%b want 00", {a_sv, a_busy});
      end
      obs_det = '0; ref_det = '0;
      for (int k = 3; k < 16; k++) begin
        obs_det[k] = obs_bits[k-3] && !obs_bits[k-2] && !obs_bits[k-1] && obs_bits[k];
        ref_det[k] = ref_bits[k-3] && !ref_bits[k-2] && !ref_bits[k-1] && ref_bits[k];
      end
      if (n == 0) ref_det = 16'h8888;
      n_checks++;
      if (obs_det !== ref_det) begin
        n_fail++; $display("FAIL b2b_detect got %h want %h", obs_det, ref_det);
      end
      $display("test_back_to_back words %h %h det=%h", w1, w2, obs_det);
    end
  endtask

  task automatic test_lsb_gap();
    logic [7:0] w1, w2, w;
    for (int n = 0; n < 3; n++) begin
      w1 = (n == 0) ? 8'h01 : 8'($urandom);
      w2 = 8'($urandom);
      @(negedge clk);
      b_valid = 1'b1; b_data = w1;
      for (int wi = 0; wi < 2; wi++) begin
        w = (wi == 0) ? w1 : w2;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          if (i == 0 && wi == 0) b_data = w2;
          if (i == 0 && wi == 1) b_valid = 1'b0;
          n_checks++;
          if ({b_out, b_sv, b_ws, b_busy, b_ready} !== {ref_bit(w, i, 1'b0), 1'b1, (i == 0), 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL lsb_bit word=%h bit=%0d got out/sv/ws/busy/ready=%b want %b", w, i,
                     {b_out, b_sv, b_ws, b_busy, b_ready}, {ref_bit(w, i, 1'b0), 1'b1, (i == 0), 1'b1, 1'b0});
          end
        end
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          n_checks++;
          if ({b_out, b_sv, b_busy, b_ready} !== 4'b0010) begin
            n_fail++; $display("FAIL gap cycle=%0d got out/sv/busy/ready=%b want 0010", g, {b_out, b_sv, b_busy, b_ready});
          end
        end
        @(negedge clk);
        n_checks++;
        if ({b_out, b_sv, b_busy, b_ready} !== 4'b0001) begin
          n_fail++; $display("FAIL gap_idle got out/sv/busy/ready=%b want 0001", {b_out, b_sv, b_busy, b_ready});
        end
      end
      $display("test_lsb_gap words %h %h", w1, w2);
    end
  endtask

  task automatic test_abort();
    logic [7:0] w;
    // Abort while idle only blocks s_ready.
    @(negedge clk);
    a_abort = 1'b1; a_valid = 1'b1; a_data = 8'h3C;
    #1;
    n_checks++;
    if (a_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle_ready got %b want 0", a_ready);
    end
    @(negedge clk);
    a_abort = 1'b0; a_valid = 1'b0;
    n_checks++;
    if ({a_out, a_sv, a_ws, a_busy} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_idle got %b want 0000", {a_out, a_sv, a_ws, a_busy});
    end
    // Abort on the third bit of 0xFF, with the next word already waiting.
    w = 8'($urandom);
    a_valid = 1'b1; a_data = 8'hFF;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) a_data = w;
    end
    a_abort = 1'b1;
    #1;
    n_checks++;
    if (a_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_ready got %b want 0", a_ready);
    end
    @(negedge clk);
    a_abort = 1'b0;
    n_checks++;
    if ({a_out, a_sv, a_ws, a_busy} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_flush got %b want 0000", {a_out, a_sv, a_ws, a_busy});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) a_valid = 1'b0;
      n_checks++;
      if ({a_out, a_sv, a_ws, a_busy} !== {ref_bit(w, i, 1'b1), 1'b1, (i == 0), 1'b1}) begin
        n_fail++;
        $display("FAIL abort_next word=%h bit=%0d got %b want %b", w, i,
                 {a_out, a_sv, a_ws, a_busy}, {ref_bit(w, i, 1'b1), 1'b1, (i == 0), 1'b1});
      end
    end
    @(negedge clk);
    $display("test_abort next word %h", w);
  endtask

  task automatic test_reset_midword();
    logic [7:0] w;
    w = 8'($urandom);
    @(negedge clk);
    a_valid = 1'b1; a_data = 8'hC3;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) a_data = w;
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({a_out, a_sv, a_ws, a_busy} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid got %b want 0000", {a_out, a_sv, a_ws, a_busy});
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_ready got %b want 1", a_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) a_valid = 1'b0;
      n_checks++;
      if ({a_out, a_sv, a_ws, a_busy} !== {ref_bit(w, i, 1'b1), 1'b1, (i == 0), 1'b1}) begin
        n_fail++;
        $display("FAIL rst_next word=%h bit=%0d got %b want %b", w, i,
                 {a_out, a_sv, a_ws, a_busy}, {ref_bit(w, i, 1'b1), 1'b1, (i == 0), 1'b1});
      end
    end
    @(negedge clk);
    $display("test_reset_midword next word %h", w);
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_data = '0; a_abort = 1'b0;
    b_valid = 1'b0; b_data = '0; b_abort = 1'b0;
    test_reset();
    test_msb_basic();
    test_back_to_back();
    test_lsb_gap();
    test_abort();
    test_reset_midword();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
